fetch_sequencer: RTL

Sequences the single-cycle processor's Instruction_Memory: owns the program counter, drives the address into the combinational instruction memory and registers the fetched word. It presents the word to decode through a valid/ready handshake. It also handles branch/jump redirects, downstream stalls, a halt instruction and misaligned-target faults. Sits between Instruction_Memory and the decode/control stage.

---
 rtl/fetch_sequencer_pkg.sv | 26 ++
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared widths, the halt opcode and the sequencer state encoding used by
// fetch_sequencer and by anything that needs to decode its state.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;

  // Instruction word that stops fetching until a resume or redirect.
  localparam logic [INST_WIDTH-1:0] HALT_OPCODE = 32'hFC00_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Word-aligned targets have both low address bits clear.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter of the single-cycle core. Drives the address into
// the combinational Instruction_Memory, registers the returned word and offers
// it to decode over a valid/ready handshake. Handles branch/jump redirects,
// downstream stalls, the halt instruction and misaligned-redirect faults.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_pc        out  address presented to Instruction_Memory
//   imem_inst      in   word returned by Instruction_Memory for imem_pc
//   out_valid      out  out_inst/out_pc hold a fetched instruction
//   out_ready      in   decode accepts the word when out_valid is high
//   out_pc         out  address of out_inst
//   out_inst       out  registered instruction word
//   redirect_valid in   one-cycle pulse: jump to redirect_pc, flush output
//   redirect_pc    in   branch/jump target
//   resume         in   one-cycle pulse: leave HALT
//   halted         out  high while in HALT
//   fault          out  sticky misaligned-redirect flag (cleared by reset)
//   fetch_count    out  saturating count of captured instructions
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0]   PC_STEP     = 32'd4,
  parameter logic [INST_WIDTH-1:0] HALT_INST   = HALT_OPCODE,
  parameter bit                    ALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [PC_WIDTH-1:0]   imem_pc,
  input  logic [INST_WIDTH-1:0] imem_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  resume,
  output logic                  halted,
  output logic                  fault,
  output logic [31:0]           fetch_count
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [PC_WIDTH-1:0]     r_imem_pc;
  logic                    r_out_valid;
  logic [PC_WIDTH-1:0]     r_out_pc;
  logic [INST_WIDTH-1:0]   r_out_inst;
  logic                    r_halted;
  logic                    r_fault;
  logic [31:0]             r_fetch_count;

  logic                    w_redirect;     // legal redirect taken this cycle
  logic                    w_fault_set;    // misaligned redirect taken this cycle
  logic                    w_capture;      // latch imem_inst into the output
  logic                    w_drop_valid;   // halt word accepted while in HALT

  // ---------------------------------------------------------------------------
  // Next-state and control decode. A redirect outranks everything except an
  // existing fault; a transfer completing alongside a redirect is simply
  // consumed, and no capture happens in that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_redirect   = 1'b0;
    w_fault_set  = 1'b0;
    w_capture    = 1'b0;
    w_drop_valid = 1'b0;

    if (redirect_valid && (r_state != ST_FAULT)) begin
      if (ALIGN_CHECK && is_misaligned(redirect_pc[1:0])) begin
        w_fault_set = 1'b1;
        w_state_nxt = ST_FAULT;
      end else begin
        w_redirect  = 1'b1;
        w_state_nxt = ST_FETCH;
      end
    end else begin
      unique case (r_state)
        ST_BOOT: w_state_nxt = ST_FETCH;
        ST_FETCH: begin
          // Capture whenever the output slot is empty or being drained.
          if (!r_out_valid || out_ready) begin
            w_capture = 1'b1;
            if (imem_inst == HALT_INST) w_state_nxt = ST_HALT;
          end
        end
        ST_HALT: begin
          if (r_out_valid && out_ready) w_drop_valid = 1'b1;
          if (resume)                   w_state_nxt  = ST_FETCH;
        end
        ST_FAULT: ;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imem_pc     <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_inst    <= '0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      // The flags track the state being entered, so they line up with it.
      r_halted <= (w_state_nxt == ST_HALT);
      r_fault  <= (w_state_nxt == ST_FAULT);

      if (w_redirect) begin
        r_imem_pc   <= redirect_pc;
        r_out_valid <= 1'b0;
      end else if (w_fault_set) begin
        // imem_pc stays put so the faulting context can be inspected.
        r_out_valid <= 1'b0;
      end else if (w_capture) begin
        r_out_inst  <= imem_inst;
        r_out_pc    <= r_imem_pc;
        r_out_valid <= 1'b1;
        r_imem_pc   <= r_imem_pc + PC_STEP;
        if (r_fetch_count != '1) r_fetch_count <= r_fetch_count + 32'd1;
      end else if (w_drop_valid) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign imem_pc     = r_imem_pc;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_inst    = r_out_inst;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule
